multi_consumer_fsm: RTL

//  Parametrised N-channel consumer at the tail of the pipelines. Each channel

---
 rtl/multi_consumer_fsm.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/multi_consumer_fsm.sv
// N-channel round collector: captures one data beat per channel, drops idle-tagged
// beats, and emits a full round or, after TIMEOUT collect cycles, a partial one.
module multi_consumer_fsm #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_mask,
  output logic                     out_partial,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               state_o,
  output logic [CNT_W-1:0]         round_cnt,
  output logic [CNT_W-1:0]         timeout_cnt
);

  // Handshakes: a beat transfers on an edge where valid && ready are both high;
  // ready never depends on valid, and the output round is held until accepted.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e                     state_q, state_d;
  logic [NUM_CH-1:0]          full_q, full_d;
  logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       partial_q, partial_d;
  logic                       live_q;
  logic [CNT_W-1:0]           round_cnt_q, round_cnt_d;
  logic [CNT_W-1:0]           timeout_cnt_q, timeout_cnt_d;
  logic [NUM_CH-1:0]          cap;

  // live_q keeps ready low while reset is held, without a combinational reset path.
  always_comb begin
    in_ready = '0;
    if (live_q && state_q != ST_EMIT) in_ready = ~full_q;
  end

  always_comb begin
    cap = '0;
    for (int i = 0; i < NUM_CH; i++)
      cap[i] = in_valid[i] && in_ready[i] && !(&in_data[i*DATA_W +: TAG_W]);
  end

  always_comb begin
    state_d       = state_q;
    full_d        = full_q | cap;
    data_d        = data_q;
    timer_d       = timer_q;
    partial_d     = partial_q;
    round_cnt_d   = round_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    for (int i = 0; i < NUM_CH; i++)
      if (cap[i]) data_d[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (&full_d) begin
          state_d   = ST_EMIT;
          partial_d = 1'b0;
        end else if (|cap) begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_q + 1'b1;
        // A capture completing the round in the expiry cycle takes priority.
        if (&full_d) begin
          state_d   = ST_EMIT;
          partial_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          state_d   = ST_EMIT;
          partial_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d   = ST_IDLE;
          full_d    = '0;
          data_d    = '0;
          partial_d = 1'b0;
          timer_d   = '0;
          if (partial_q) begin
            if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + 1'b1;
          end else begin
            if (round_cnt_q != '1) round_cnt_d = round_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        full_d    = '0;
        data_d    = '0;
        partial_d = 1'b0;
        timer_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      full_q        <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      partial_q     <= 1'b0;
      live_q        <= 1'b0;
      round_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      partial_q     <= partial_d;
      live_q        <= 1'b1;
      round_cnt_q   <= round_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign out_valid   = (state_q == ST_EMIT);
  assign out_data    = data_q;
  assign out_mask    = full_q;
  assign out_partial = partial_q;
  assign state_o     = state_q;
  assign round_cnt   = round_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
